eth_tx_framer: RTL

//  Upstream feeder for the RMII transmit stage (eth_tx). Accepts one payload per frame

---
 rtl/eth_tx_pkg.sv | 24 ++
 rtl/eth_tx_framer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the RMII transmit path (eth_tx and its framer).
// Contents: framer state encoding, payload length limits, inter-packet gap length.
// Pure declarations; no logic and no timing.
package eth_tx_pkg;

  // Framer states. IDLE/PASS accept payload; the rest stall upstream.
  typedef enum logic [2:0] {
    IDLE,
    PASS,
    PAD,
    COMMIT,
    WAIT_START,
    WAIT_END,
    IPG
  } eth_tx_framer_state_t;

  // Ethernet minimum payload; shorter frames are zero-padded up to this.
  localparam int pMIN_PAYLOAD = 46;
  // Largest payload forwarded; must not exceed the eth_tx FIFO depth.
  localparam int pMAX_PAYLOAD = 1500;
  // Idle clocks after Tx_En falls: 96 bit times at 2 bits per RMII clock.
  localparam int pIPG_CLKS    = 48;

endpackage

// File: rtl/eth_tx_framer.sv
// Upstream feeder for eth_tx: takes one payload per frame, pads/truncates it, writes the
// eth_tx FIFO one cycle after each accepted beat, pulses Eth_Pkt_Rdy, then waits out the frame
// and the inter-packet gap. S_Ready is high only in IDLE/PASS; upstream stalls otherwise.
//
// Ports:
//   Clk, Rst_n                      RMII reference clock, async active-low reset
//   S_Data/S_Valid/S_Last/S_Ready   payload byte stream (valid/ready/last)
//   Tx_En                           from eth_tx; high while the frame is on the wire
//   Eth_Byte/Eth_Byte_Valid         eth_tx FIFO write port
//   Eth_Pkt_Rdy, Pkt_Len, Pkt_Trunc frame commit pulse, forwarded length, truncation pulse
//   Pkt_Done                        pulse when the inter-packet gap has expired
module eth_tx_framer
  import eth_tx_pkg::*;
#(
  parameter int pMIN_PAYLOAD = eth_tx_pkg::pMIN_PAYLOAD,
  parameter int pMAX_PAYLOAD = eth_tx_pkg::pMAX_PAYLOAD,
  parameter int pIPG_CLKS    = eth_tx_pkg::pIPG_CLKS
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [7:0]  S_Data,
  input  logic        S_Valid,
  input  logic        S_Last,
  output logic        S_Ready,
  input  logic        Tx_En,
  output logic [7:0]  Eth_Byte,
  output logic        Eth_Byte_Valid,
  output logic        Eth_Pkt_Rdy,
  output logic [10:0] Pkt_Len,
  output logic        Pkt_Trunc,
  output logic        Pkt_Done
);

  localparam int          IPG_W    = $clog2(pIPG_CLKS + 1);
  localparam logic [10:0] MIN_C    = 11'(pMIN_PAYLOAD);
  localparam logic [10:0] MAX_C    = 11'(pMAX_PAYLOAD);
  localparam logic [IPG_W-1:0] IPG_LOAD = IPG_W'(pIPG_CLKS - 1);

  eth_tx_framer_state_t state_q;
  logic [10:0]      cnt_q;
  logic [IPG_W-1:0] ipg_q;
  logic             trunc_q;

  logic [7:0]       eth_byte_q;
  logic             eth_byte_valid_q;
  logic             pkt_rdy_q;
  logic [10:0]      pkt_len_q;
  logic             pkt_trunc_q;
  logic             pkt_done_q;

  logic             beat;
  logic             room;
  logic [10:0]      cnt_inc;
  logic [10:0]      cnt_d;

  assign S_Ready = (state_q == IDLE) || (state_q == PASS);
  assign beat    = S_Valid && S_Ready;

  // room: the current beat still fits under the truncation limit.
  // cnt_d is the byte count once this PASS beat has been handled, used for the pad decision.
  always_comb begin
    room    = 1'b0;
    cnt_inc = cnt_q + 11'd1;
    cnt_d   = cnt_q;
    if (cnt_q < MAX_C) begin
      room  = 1'b1;
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      ipg_q            <= '0;
      trunc_q          <= 1'b0;
      eth_byte_q       <= '0;
      eth_byte_valid_q <= 1'b0;
      pkt_rdy_q        <= 1'b0;
      pkt_len_q        <= '0;
      pkt_trunc_q      <= 1'b0;
      pkt_done_q       <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them.
      eth_byte_valid_q <= 1'b0;
      pkt_rdy_q        <= 1'b0;
      pkt_trunc_q      <= 1'b0;
      pkt_done_q       <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (beat) begin
            eth_byte_q       <= S_Data;
            eth_byte_valid_q <= 1'b1;
            cnt_q            <= 11'd1;
            if (S_Last) begin
              state_q <= (11'd1 < MIN_C) ? PAD : COMMIT;
            end else begin
              state_q <= PASS;
            end
          end
        end

        PASS: begin
          if (beat) begin
            if (room) begin
              eth_byte_q       <= S_Data;
              eth_byte_valid_q <= 1'b1;
              cnt_q            <= cnt_inc;
            end else begin
              // Over the limit: accept the beat so upstream drains, but drop the byte.
              trunc_q <= 1'b1;
            end
            if (S_Last) begin
              state_q <= (cnt_d < MIN_C) ? PAD : COMMIT;
            end
          end
        end

        PAD: begin
          // Entered only with cnt_q below the minimum; leave on the last pad write so
          // COMMIT lands the cycle that write becomes visible.
          eth_byte_q       <= 8'h00;
          eth_byte_valid_q <= 1'b1;
          cnt_q            <= cnt_inc;
          if (cnt_inc >= MIN_C) begin
            state_q <= COMMIT;
          end
        end

        COMMIT: begin
          pkt_rdy_q   <= 1'b1;
          pkt_len_q   <= cnt_q;
          pkt_trunc_q <= trunc_q;
          trunc_q     <= 1'b0;
          state_q     <= WAIT_START;
        end

        WAIT_START: begin
          if (Tx_En) begin
            state_q <= WAIT_END;
          end
        end

        WAIT_END: begin
          if (!Tx_En) begin
            ipg_q   <= IPG_LOAD;
            state_q <= IPG;
          end
        end

        IPG: begin
          if (ipg_q == '0) begin
            pkt_done_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= IDLE;
          end else begin
            ipg_q <= ipg_q - IPG_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Eth_Byte       = eth_byte_q;
  assign Eth_Byte_Valid = eth_byte_valid_q;
  assign Eth_Pkt_Rdy    = pkt_rdy_q;
  assign Pkt_Len        = pkt_len_q;
  assign Pkt_Trunc      = pkt_trunc_q;
  assign Pkt_Done       = pkt_done_q;

endmodule
